// File: rtl/pipe_reg_slice.sv
// Elastic valid/ready pipeline register: DEPTH stages of WIDTH bits with collapsing
// bubbles, a synchronous flush and an occupancy count for hazard/stall logic.
module pipe_reg_slice #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    generate
        if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
            $error("pipe_reg_slice: DEPTH must be in 1..8");
        end
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("pipe_reg_slice: WIDTH must be in 1..64");
        end
    endgenerate

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q   [DEPTH];
    logic [WIDTH-1:0] d_d   [DEPTH];
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [DEPTH:0]   en;
    logic [CW-1:0]    count_q, count_d;
    logic             in_xfer, out_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_src
            if (gi == 0) begin : g_head
                assign src_v[gi] = in_valid;
                assign src_d[gi] = in_data;
            end else begin : g_link
                assign src_v[gi] = v_q[gi-1];
                assign src_d[gi] = d_q[gi-1];
            end
        end
    endgenerate

    // Ready ripples back from the output; an empty stage always advances, so gaps collapse.
    always_comb begin
        en        = '0;
        en[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            en[i] = !v_q[i] | en[i+1];
        end
    end

    assign in_ready  = en[0] & ~flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign count     = count_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                v_d[i] = 1'b0;
            end else if (en[i]) begin
                v_d[i] = src_v[i];
                if (src_v[i]) begin
                    d_d[i] = src_d[i];
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= RESET_VALUE;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            d_q     <= d_d;
        end
    end
endmodule

// File: tb/tb_pipe_reg_slice.sv
// Scoreboard bench for pipe_reg_slice: several instances cover streaming, backpressure,
// bubble collapse, flush, asynchronous reset and random width/depth sweeps.
module tb_pipe_reg_slice;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] A_RST = 32'hDEAD_BEEF;
    localparam logic [31:0] B_RST = 32'hC0FF_EE00;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_count;
    logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    logic [2:0]  c_count;
    logic        s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    logic [0:0]  s1_in_data, s1_out_data;
    logic [0:0]  s1_count;
    logic        s8_flush, s8_in_valid, s8_in_ready, s8_out_valid, s8_out_ready;
    logic [63:0] s8_in_data, s8_out_data;
    logic [3:0]  s8_count;

    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] qc [$];
    logic [0:0]  q1 [$];
    logic [63:0] q8 [$];

    pipe_reg_slice #(.WIDTH(32), .DEPTH(2), .RESET_VALUE(A_RST)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(a_flush), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .count(a_count));
    pipe_reg_slice #(.WIDTH(32), .DEPTH(3), .RESET_VALUE(B_RST)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(b_flush), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .count(b_count));
    pipe_reg_slice #(.WIDTH(32), .DEPTH(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .flush(c_flush), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .in_data(c_in_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .count(c_count));
    pipe_reg_slice #(.WIDTH(1), .DEPTH(1)) dut_s1 (
        .clk(clk), .reset_n(reset_n), .flush(s1_flush), .in_valid(s1_in_valid),
        .in_ready(s1_in_ready), .in_data(s1_in_data), .out_valid(s1_out_valid),
        .out_ready(s1_out_ready), .out_data(s1_out_data), .count(s1_count));
    pipe_reg_slice #(.WIDTH(64), .DEPTH(8)) dut_s8 (
        .clk(clk), .reset_n(reset_n), .flush(s8_flush), .in_valid(s8_in_valid),
        .in_ready(s8_in_ready), .in_data(s8_in_data), .out_valid(s8_out_valid),
        .out_ready(s8_out_ready), .out_data(s8_out_data), .count(s8_count));

    // Drive one cycle's inputs after the falling edge and sample the transfers it will make.
    task automatic a_drive(input logic fl, input logic iv, input logic [31:0] id, input logic ordy,
                           output logic ix, output logic ox, output logic [31:0] od);
        @(negedge clk);
        a_flush = fl; a_in_valid = iv; a_in_data = id; a_out_ready = ordy;
        #1;
        ix = a_in_valid & a_in_ready;
        ox = a_out_valid & a_out_ready;
        od = a_out_data;
    endtask

    task automatic b_drive(input logic fl, input logic iv, input logic [31:0] id, input logic ordy,
                           output logic ix, output logic ox, output logic [31:0] od);
        @(negedge clk);
        b_flush = fl; b_in_valid = iv; b_in_data = id; b_out_ready = ordy;
        #1;
        ix = b_in_valid & b_in_ready;
        ox = b_out_valid & b_out_ready;
        od = b_out_data;
    endtask

    task automatic c_drive(input logic fl, input logic iv, input logic [31:0] id, input logic ordy,
                           output logic ix, output logic ox, output logic [31:0] od);
        @(negedge clk);
        c_flush = fl; c_in_valid = iv; c_in_data = id; c_out_ready = ordy;
        #1;
        ix = c_in_valid & c_in_ready;
        ox = c_out_valid & c_out_ready;
        od = c_out_data;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        checks++; if (a_out_data !== A_RST) begin errors++; $display("FAIL reset_out_data: got %h expected %h", a_out_data, A_RST); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        checks++; if (b_out_data !== B_RST) begin errors++; $display("FAIL reset_b_out_data: got %h expected %h", b_out_data, B_RST); end
        checks++; if (s8_out_valid !== 1'b0 || c_count !== 3'd0) begin errors++; $display("FAIL reset_others: got valid %b count %0d expected 0 0", s8_out_valid, c_count); end
        reset_n = 1'b1;
    endtask

    task automatic test_streaming();
        logic ix, ox;
        logic [31:0] od, exp;
        int first_in = -1, first_out = -1, n_out = 0;
        for (int k = 0; k < 20; k++) begin
            a_drive(1'b0, k < 16, 32'(k + 1), 1'b1, ix, ox, od);
            if (k < 16) begin
                checks++; if (ix !== 1'b1) begin errors++; $display("FAIL stream_in_ready: cycle %0d got %b expected 1", k, ix); end
            end
            if (ox) begin
                checks++;
                if (qa.size() == 0) begin errors++; $display("FAIL stream_spurious: cycle %0d got %h expected no output", k, od); end
                else begin
                    exp = qa.pop_front();
                    if (od !== exp) begin errors++; $display("FAIL stream_data: cycle %0d got %h expected %h", k, od, exp); end
                end
                if (first_out < 0) first_out = k;
                n_out++;
            end
            if (ix) begin
                qa.push_back(32'(k + 1));
                if (first_in < 0) first_in = k;
            end
            @(posedge clk); #1;
            checks++; if (32'(a_count) !== 32'(qa.size())) begin errors++; $display("FAIL stream_count: cycle %0d got %0d expected %0d", k, a_count, qa.size()); end
            if (k == 8) begin
                checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL stream_full_count: got %0d expected 2", a_count); end
            end
        end
        checks++; if (first_out - first_in !== 2) begin errors++; $display("FAIL stream_latency: got %0d expected 2", first_out - first_in); end
        checks++; if (n_out !== 16) begin errors++; $display("FAIL stream_total: got %0d expected 16", n_out); end
    endtask

    task automatic test_backpressure();
        logic ix, ox, exp_ix;
        logic [31:0] od, exp, id;
        logic [31:0] words [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
        int ptr = 0, n_out = 0;
        for (int k = 0; k < 12; k++) begin
            id = (ptr < 4) ? words[ptr] : 32'h0;
            b_drive(1'b0, ptr < 4, id, k >= 5, ix, ox, od);
            if (k <= 5) begin
                exp_ix = (k < 3) || (k == 5);
                checks++; if (ix !== exp_ix) begin errors++; $display("FAIL bp_accept: cycle %0d got %b expected %b", k, ix, exp_ix); end
            end
            if (ox) begin
                checks++;
                if (qb.size() == 0) begin errors++; $display("FAIL bp_spurious: cycle %0d got %h expected no output", k, od); end
                else begin
                    exp = qb.pop_front();
                    if (od !== exp) begin errors++; $display("FAIL bp_data: cycle %0d got %h expected %h", k, od, exp); end
                end
                n_out++;
            end
            if (ix) begin qb.push_back(id); ptr++; end
            @(posedge clk); #1;
            checks++; if (32'(b_count) !== 32'(qb.size())) begin errors++; $display("FAIL bp_count: cycle %0d got %0d expected %0d", k, b_count, qb.size()); end
            if (k == 4) begin
                checks++; if (b_count !== 2'd3) begin errors++; $display("FAIL bp_full_count: got %0d expected 3", b_count); end
            end
        end
        checks++; if (n_out !== 4) begin errors++; $display("FAIL bp_total: got %0d expected 4", n_out); end
    endtask

    task automatic test_bubble();
        logic ix, ox;
        logic [31:0] od, exp;
        int out_k [2] = '{0, 0};
        int n_out = 0;
        for (int k = 0; k < 16; k++) begin
            c_drive(1'b0, (k == 0) || (k == 3), (k == 0) ? 32'h11 : 32'h22, k >= 9, ix, ox, od);
            if (k == 0 || k == 3) begin
                checks++; if (ix !== 1'b1) begin errors++; $display("FAIL bubble_accept: cycle %0d got %b expected 1", k, ix); end
            end
            if (ox) begin
                checks++;
                if (qc.size() == 0) begin errors++; $display("FAIL bubble_spurious: cycle %0d got %h expected no output", k, od); end
                else begin
                    exp = qc.pop_front();
                    if (od !== exp) begin errors++; $display("FAIL bubble_data: cycle %0d got %h expected %h", k, od, exp); end
                end
                if (n_out < 2) out_k[n_out] = k;
                n_out++;
            end
            if (ix) qc.push_back(c_in_data);
            @(posedge clk); #1;
            checks++; if (32'(c_count) !== 32'(qc.size())) begin errors++; $display("FAIL bubble_count: cycle %0d got %0d expected %0d", k, c_count, qc.size()); end
            if (k == 3) begin
                checks++; if (c_count !== 3'd2) begin errors++; $display("FAIL bubble_held: got %0d expected 2", c_count); end
                checks++; if (c_out_valid !== 1'b1 || c_out_data !== 32'h11) begin errors++; $display("FAIL bubble_head: got valid %b data %h expected 1 00000011", c_out_valid, c_out_data); end
            end
        end
        checks++; if (n_out !== 2) begin errors++; $display("FAIL bubble_total: got %0d expected 2", n_out); end
        checks++; if (out_k[1] - out_k[0] !== 1) begin errors++; $display("FAIL bubble_consecutive: got gap %0d expected 1", out_k[1] - out_k[0]); end
    endtask

    task automatic test_flush();
        logic ix, ox;
        logic [31:0] od, exp;
        logic        fl_t [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        iv_t [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        or_t [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] id_t [7] = '{32'h5, 32'h6, 32'h7, 32'h8, 32'h0, 32'h0, 32'h0};
        int n_out = 0;
        for (int k = 0; k < 7; k++) begin
            a_drive(fl_t[k], iv_t[k], id_t[k], or_t[k], ix, ox, od);
            if (k == 2) begin
                checks++; if (ix !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", ix); end
                checks++; if (ox !== 1'b1) begin errors++; $display("FAIL flush_deliver: got %b expected 1", ox); end
            end
            if (ox) begin
                checks++;
                if (qa.size() == 0) begin errors++; $display("FAIL flush_spurious: cycle %0d got %h expected no output", k, od); end
                else begin
                    exp = qa.pop_front();
                    if (od !== exp) begin errors++; $display("FAIL flush_data: cycle %0d got %h expected %h", k, od, exp); end
                end
                n_out++;
            end
            if (fl_t[k]) qa.delete();
            if (ix) qa.push_back(id_t[k]);
            @(posedge clk); #1;
            checks++; if (32'(a_count) !== 32'(qa.size())) begin errors++; $display("FAIL flush_count: cycle %0d got %0d expected %0d", k, a_count, qa.size()); end
            if (k == 2) begin
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", a_out_valid); end
            end
        end
        checks++; if (n_out !== 2) begin errors++; $display("FAIL flush_total: got %0d expected 2", n_out); end
    endtask

    task automatic test_mid_reset();
        logic ix, ox;
        logic [31:0] od, exp;
        int in_k = -1, out_k = -1;
        for (int k = 0; k < 3; k++) begin
            b_drive(1'b0, 1'b1, 32'(k + 1), 1'b0, ix, ox, od);
        end
        @(posedge clk); #3;
        checks++; if (b_count !== 2'd3) begin errors++; $display("FAIL mreset_prefill: got %0d expected 3", b_count); end
        reset_n = 1'b0;
        b_in_valid = 1'b0;
        #1;
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL mreset_out_valid: got %b expected 0", b_out_valid); end
        checks++; if (b_count !== 2'd0) begin errors++; $display("FAIL mreset_count: got %0d expected 0", b_count); end
        checks++; if (b_out_data !== B_RST) begin errors++; $display("FAIL mreset_out_data: got %h expected %h", b_out_data, B_RST); end
        qa.delete(); qb.delete(); qc.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            b_drive(1'b0, k == 0, 32'h99, 1'b1, ix, ox, od);
            if (ox) begin
                checks++;
                if (qb.size() == 0) begin errors++; $display("FAIL mreset_spurious: cycle %0d got %h expected no output", k, od); end
                else begin
                    exp = qb.pop_front();
                    if (od !== exp) begin errors++; $display("FAIL mreset_data: cycle %0d got %h expected %h", k, od, exp); end
                end
                out_k = k;
            end
            if (ix) begin qb.push_back(32'h99); in_k = k; end
        end
        checks++; if (out_k - in_k !== 3 || in_k < 0) begin errors++; $display("FAIL mreset_latency: got %0d expected 3", out_k - in_k); end
    endtask

    task automatic test_sweep_w1();
        logic ix, ox;
        logic [0:0] od, exp, id;
        q1.delete();
        for (int k = 0; k < 10020; k++) begin
            @(negedge clk);
            s1_flush     = 1'b0;
            s1_in_valid  = (k < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            s1_in_data   = 1'($urandom_range(0, 1));
            s1_out_ready = (k < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            ix = s1_in_valid & s1_in_ready; ox = s1_out_valid & s1_out_ready;
            od = s1_out_data; id = s1_in_data;
            if (ox) begin
                checks++;
                if (q1.size() == 0) begin errors++; $display("FAIL w1_spurious: cycle %0d got %b expected no output", k, od); end
                else begin
                    exp = q1.pop_front();
                    if (od !== exp) begin errors++; $display("FAIL w1_data: cycle %0d got %b expected %b", k, od, exp); end
                end
            end
            if (ix) q1.push_back(id);
            @(posedge clk); #1;
            checks++; if (32'(s1_count) !== 32'(q1.size())) begin errors++; $display("FAIL w1_count: cycle %0d got %0d expected %0d", k, s1_count, q1.size()); end
        end
        checks++; if (q1.size() != 0) begin errors++; $display("FAIL w1_drain: got %0d left expected 0", q1.size()); end
    endtask

    task automatic test_sweep_w64();
        logic ix, ox;
        logic [63:0] od, exp, id;
        q8.delete();
        for (int k = 0; k < 10040; k++) begin
            @(negedge clk);
            s8_flush     = 1'b0;
            s8_in_valid  = (k < 10000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            s8_in_data   = {$urandom, $urandom};
            s8_out_ready = (k < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            ix = s8_in_valid & s8_in_ready; ox = s8_out_valid & s8_out_ready;
            od = s8_out_data; id = s8_in_data;
            if (ox) begin
                checks++;
                if (q8.size() == 0) begin errors++; $display("FAIL w64_spurious: cycle %0d got %h expected no output", k, od); end
                else begin
                    exp = q8.pop_front();
                    if (od !== exp) begin errors++; $display("FAIL w64_data: cycle %0d got %h expected %h", k, od, exp); end
                end
            end
            if (ix) q8.push_back(id);
            @(posedge clk); #1;
            checks++; if (32'(s8_count) !== 32'(q8.size())) begin errors++; $display("FAIL w64_count: cycle %0d got %0d expected %0d", k, s8_count, q8.size()); end
        end
        checks++; if (q8.size() != 0) begin errors++; $display("FAIL w64_drain: got %0d left expected 0", q8.size()); end
    endtask

    initial begin
        reset_n = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
        s1_flush = 1'b0; s1_in_valid = 1'b0; s1_in_data = '0; s1_out_ready = 1'b0;
        s8_flush = 1'b0; s8_in_valid = 1'b0; s8_in_data = '0; s8_out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_mid_reset();
        test_sweep_w1();
        test_sweep_w64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
